// File: rtl/firebird7_in_gate1_tessent_sib_multi.sv
// Chain of NUM_SEG IJTAG segment insertion bits, each gating its own downstream segment,
// with per-segment hard-close locks, optional open-state capture and a retimed scan-out.
module firebird7_in_gate1_tessent_sib_multi #(
    parameter int unsigned        NUM_SEG         = 4,
    parameter bit                 CAPTURE_MODE    = 1'b0,
    parameter logic [NUM_SEG-1:0] RESET_OPEN_MASK = '0
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_si,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
    output logic               ijtag_so,
    input  logic [NUM_SEG-1:0] ijtag_seg_lock,
    output logic [NUM_SEG-1:0] ijtag_to_si,
    input  logic [NUM_SEG-1:0] ijtag_from_so,
    output logic [NUM_SEG-1:0] ijtag_to_sel,
    output logic [NUM_SEG-1:0] ijtag_open
);

    logic [NUM_SEG-1:0] sib_q, sib_d;
    logic [NUM_SEG-1:0] latch_q, latch_d;
    logic [NUM_SEG-1:0] en_q;
    logic [NUM_SEG-1:0] chain_in;
    logic [NUM_SEG-1:0] shift_val;
    logic [NUM_SEG-1:0] reset_open;
    logic               so_q;

    always_comb begin
        chain_in    = '0;
        chain_in[0] = ijtag_si;
        for (int unsigned k = 1; k < NUM_SEG; k++) begin
            chain_in[k] = sib_q[k-1];
        end
    end

    // An open cell is fed by its own segment, a closed one by the previous hop.
    assign shift_val = (latch_q & ijtag_from_so) | (~latch_q & chain_in);

    always_comb begin
        sib_d = sib_q;
        if (ijtag_ce && ijtag_sel) begin
            sib_d = CAPTURE_MODE ? latch_q : '0;
        end else if (ijtag_se && ijtag_sel) begin
            sib_d = shift_val;
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sib_q <= '0;
        end else begin
            sib_q <= sib_d;
        end
    end

    assign reset_open = RESET_OPEN_MASK & ~ijtag_seg_lock;

    // Locks clear the latch on every negedge, update or not.
    always_comb begin
        latch_d = latch_q & ~ijtag_seg_lock;
        if (ijtag_ue && ijtag_sel) begin
            latch_d = sib_q & ~ijtag_seg_lock;
        end
    end

    always_ff @(negedge ijtag_tck) begin
        if (ijtag_reset) begin
            latch_q <= reset_open;
            en_q    <= reset_open;
            so_q    <= 1'b0;
        end else begin
            latch_q <= latch_d;
            en_q    <= latch_q;
            so_q    <= sib_q[NUM_SEG-1];
        end
    end

    assign ijtag_to_si  = chain_in;
    assign ijtag_to_sel = en_q & {NUM_SEG{ijtag_sel}};
    assign ijtag_open   = en_q;
    assign ijtag_so     = so_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_sib_multi.sv
// Bench for the multi-SIB: two instances (plain capture, mask 0 / readback capture, mask 0100)
// with dummy instrument segments, a vector-level reference model and directed checkpoints.
module tb_firebird7_in_gate1_tessent_sib_multi;

    localparam int       SEG_LEN [4] = '{2, 2, 3, 1};
    localparam bit       CM      [2] = '{1'b0, 1'b1};
    localparam logic [3:0] MASK  [2] = '{4'b0000, 4'b0100};

    logic       tck = 1'b0;
    logic       reset, sel, si, ce, se, ue;
    logic [3:0] lock;
    logic [1:0] so;
    logic [3:0] to_si   [2];
    logic [3:0] from_so [2];
    logic [3:0] to_sel  [2];
    logic [3:0] open_st [2];
    logic [7:0] seg_q   [2][4];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_sib_multi #(
        .NUM_SEG(4), .CAPTURE_MODE(1'b0), .RESET_OPEN_MASK(4'b0000)
    ) u_dut_a (
        .ijtag_tck(tck), .ijtag_reset(reset), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so[0]),
        .ijtag_seg_lock(lock), .ijtag_to_si(to_si[0]), .ijtag_from_so(from_so[0]),
        .ijtag_to_sel(to_sel[0]), .ijtag_open(open_st[0])
    );

    firebird7_in_gate1_tessent_sib_multi #(
        .NUM_SEG(4), .CAPTURE_MODE(1'b1), .RESET_OPEN_MASK(4'b0100)
    ) u_dut_b (
        .ijtag_tck(tck), .ijtag_reset(reset), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so[1]),
        .ijtag_seg_lock(lock), .ijtag_to_si(to_si[1]), .ijtag_from_so(from_so[1]),
        .ijtag_to_sel(to_sel[1]), .ijtag_open(open_st[1])
    );

    // Dummy instrument segments: plain shift registers that move only while selected.
    always @(posedge tck) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (reset) begin
                    seg_q[i][k] <= '0;
                end else if (se && !ce && to_sel[i][k]) begin
                    seg_q[i][k] <= {seg_q[i][k][6:0], to_si[i][k]};
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            from_so[i] = '0;
            for (int k = 0; k < 4; k++) begin
                from_so[i][k] = seg_q[i][k][SEG_LEN[k]-1];
            end
        end
    end

    // Reference model: whole-vector state per instance.
    logic [3:0] m_sib   [2];
    logic [3:0] m_latch [2];
    logic [3:0] m_en    [2];
    logic [1:0] m_so;

    // Each host-path hop: an open cell takes its segment's output, a closed one the hop before.
    function automatic logic [3:0] host_shift(input logic [3:0] cells, input logic [3:0] opened,
                                              input logic s_in, input logic [3:0] seg_out);
        logic [3:0] r;
        logic       feed;
        feed = s_in;
        for (int k = 0; k < 4; k++) begin
            r[k] = opened[k] ? seg_out[k] : feed;
            feed = cells[k];
        end
        return r;
    endfunction

    always @(posedge tck) begin
        for (int i = 0; i < 2; i++) begin
            if (reset)            m_sib[i] <= 4'b0000;
            else if (sel && ce)   m_sib[i] <= CM[i] ? m_latch[i] : 4'b0000;
            else if (sel && se)   m_sib[i] <= host_shift(m_sib[i], m_latch[i], si, from_so[i]);
        end
    end

    always @(negedge tck) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_latch[i] <= MASK[i] & ~lock;
                m_en[i]    <= MASK[i] & ~lock;
                m_so[i]    <= 1'b0;
            end else begin
                m_latch[i] <= ((sel && ue) ? m_sib[i] : m_latch[i]) & ~lock;
                m_en[i]    <= m_latch[i];
                m_so[i]    <= m_sib[i][3];
            end
        end
    end

    task automatic check(input string name, input int inst, input logic [3:0] got,
                         input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d got %b expected %b at %0t", name, inst, got, exp, $time);
        end
    endtask

    always @(posedge tck or negedge tck) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("so", i, {3'b000, so[i]}, {3'b000, m_so[i]});
                check("to_si", i, to_si[i], {m_sib[i][2:0], si});
                check("to_sel", i, to_sel[i], m_en[i] & {4{sel}});
                check("open", i, open_st[i], m_en[i]);
            end
        end
    end

    // Inputs are applied 2 time units after a posedge, away from both edges.
    task automatic step(input logic ce_v, input logic se_v, input logic ue_v, input logic si_v);
        ce = ce_v;
        se = se_v;
        ue = ue_v;
        si = si_v;
        @(posedge tck);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic shift_bits(input logic [6:0] pat, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            step(1'b0, 1'b1, 1'b0, pat[b]);
        end
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b1;
        si    = 1'b0;
        ce    = 1'b0;
        se    = 1'b0;
        ue    = 1'b0;
        lock  = 4'b0000;
        do_reset();
        chk_en = 1'b1;

        check("rst_to_sel", 0, to_sel[0], 4'b0000);
        check("rst_so", 0, {3'b000, so[0]}, 4'b0000);
        check("rst_to_sel", 1, to_sel[1], 4'b0100);
        check("rst_open", 1, open_st[1], 4'b0100);

        // Open segment 0; enable lags the latch by one negedge.
        shift_bits(7'b0000001, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("upd_open_lag", 0, open_st[0], 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("upd_to_sel", 0, to_sel[0], 4'b0001);

        // Open segment 2 (3 bits) and walk a one through the 7-bit host path.
        do_reset();
        shift_bits(7'b0000100, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("seg2_open", 0, open_st[0], 4'b0100);
        shift_bits(7'b1000000, 7);
        check("walk_so_pre", 0, {3'b000, so[0]}, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("walk_so", 0, {3'b000, so[0]}, 4'b0001);

        // Load latch 1010 into the readback instance, then capture.
        do_reset();
        shift_bits(7'b1000010, 7);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rb_open", 1, open_st[1], 4'b1010);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rb_so", 1, {3'b000, so[1]}, 4'b0001);
        check("cap0_so", 0, {3'b000, so[0]}, 4'b0000);
        shift_bits(7'b0000000, 4);

        // Lock segment 1 with no update, then try to reopen it.
        lock = 4'b0010;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lock_open_lag", 0, open_st[0], 4'b0010);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lock_open", 0, open_st[0], 4'b0000);
        check("lock_to_sel", 0, to_sel[0], 4'b0000);
        shift_bits(7'b0001111, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lock_upd_open", 0, open_st[0], 4'b1101);
        check("sib_ones", 0, {1'b0, to_si[0][3:1]}, 4'b0111);

        // Capture and shift together: capture wins.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ce_se_sib", 0, {1'b0, to_si[0][3:1]}, 4'b0000);

        // Deselected: segments not selected, registers hold.
        lock = 4'b0000;
        do_reset();
        sel = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("nosel_to_sel", 0, to_sel[0], 4'b0000);
        check("nosel_to_sel", 1, to_sel[1], 4'b0000);
        check("nosel_open", 1, open_st[1], 4'b0100);
        shift_bits(7'b0000011, 2);

        // Reset in the middle of a shift.
        sel = 1'b1;
        shift_bits(7'b0000011, 2);
        reset = 1'b1;
        shift_bits(7'b0000011, 2);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_to_sel", 1, to_sel[1], 4'b0100);
        check("midrst_sib", 0, {1'b0, to_si[0][3:1]}, 4'b0000);
        check("midrst_so", 0, {3'b000, so[0]}, 4'b0000);

        chk_en = 1'b0;
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
